// File: rtl/l15_port_arbiter.sv
// rtl/l15_port_arbiter.sv - shares one L1.5 transducer port between IF and DM, one transaction in flight
// Optional grant/wait counters when L15_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module l15_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req_val,
    input  logic [4:0]  i_if_rqtype,
    input  logic [2:0]  i_if_size,
    input  logic [31:0] i_if_address,
    input  logic [31:0] i_if_data,
    output logic        o_if_header_ack,
    output logic        o_if_resp_val,
    output logic [63:0] o_if_resp_data_0,
    output logic [63:0] o_if_resp_data_1,
    output logic [3:0]  o_if_resp_returntype,
    input  logic        i_if_resp_ack,
    input  logic        i_dm_req_val,
    input  logic [4:0]  i_dm_rqtype,
    input  logic [2:0]  i_dm_size,
    input  logic [31:0] i_dm_address,
    input  logic [31:0] i_dm_data,
    output logic        o_dm_header_ack,
    output logic        o_dm_resp_val,
    output logic [63:0] o_dm_resp_data_0,
    output logic [63:0] o_dm_resp_data_1,
    output logic [3:0]  o_dm_resp_returntype,
    input  logic        i_dm_resp_ack,
    output logic        o_transducer_l15_val,
    output logic [4:0]  o_transducer_l15_rqtype,
    output logic [2:0]  o_transducer_l15_size,
    output logic [31:0] o_transducer_l15_address,
    output logic [31:0] o_transducer_l15_data,
    input  logic        i_l15_transducer_header_ack,
    input  logic        i_l15_transducer_val,
    input  logic [63:0] i_l15_transducer_data_0,
    input  logic [63:0] i_l15_transducer_data_1,
    input  logic [3:0]  i_l15_transducer_returntype,
    output logic        o_transducer_l15_req_ack,
    output logic        o_owner,
    output logic        o_busy,
    output logic        o_dm_pending
`ifdef L15_ARB_PERF_EN
    ,
    output logic [31:0] o_perf_if_grants,
    output logic [31:0] o_perf_dm_grants,
    output logic [31:0] o_perf_if_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_l15_val;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_rqtype;
    logic [2:0]       r_size;
    logic [31:0]      r_address;
    logic [31:0]      r_data;

    logic w_idle;
    logic w_if_starved;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_resp_fwd;
    logic w_owner_ack;
    logic w_resp_done;

    // Grants are combinational so header_ack lands in the same cycle the request is seen.
    assign w_idle       = (r_state == ST_IDLE) && !i_rst;
    assign w_if_starved = i_if_req_val && (r_cnt == CNT_W'(STARVE_LIMIT));
    assign w_grant_dm   = w_idle && i_dm_req_val && !w_if_starved;
    assign w_grant_if   = w_idle && i_if_req_val && !w_grant_dm;

    assign w_resp_fwd  = (r_state == ST_RESP) && i_l15_transducer_val;
    assign w_owner_ack = r_owner ? i_dm_resp_ack : i_if_resp_ack;
    assign w_resp_done = w_resp_fwd && w_owner_ack;

    assign o_if_header_ack      = w_grant_if;
    assign o_dm_header_ack      = w_grant_dm;
    assign o_dm_pending         = i_dm_req_val && !w_grant_dm;
    assign o_if_resp_val        = w_resp_fwd && !r_owner;
    assign o_if_resp_data_0     = o_if_resp_val ? i_l15_transducer_data_0 : '0;
    assign o_if_resp_data_1     = o_if_resp_val ? i_l15_transducer_data_1 : '0;
    assign o_if_resp_returntype = o_if_resp_val ? i_l15_transducer_returntype : '0;
    assign o_dm_resp_val        = w_resp_fwd && r_owner;
    assign o_dm_resp_data_0     = o_dm_resp_val ? i_l15_transducer_data_0 : '0;
    assign o_dm_resp_data_1     = o_dm_resp_val ? i_l15_transducer_data_1 : '0;
    assign o_dm_resp_returntype = o_dm_resp_val ? i_l15_transducer_returntype : '0;

    assign o_transducer_l15_req_ack = w_resp_done;
    assign o_transducer_l15_val     = r_l15_val;
    assign o_transducer_l15_rqtype  = r_rqtype;
    assign o_transducer_l15_size    = r_size;
    assign o_transducer_l15_address = r_address;
    assign o_transducer_l15_data    = r_data;
    assign o_owner                  = r_owner;
    assign o_busy                   = (r_state != ST_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_l15_val <= 1'b0;
            r_cnt     <= '0;
            r_rqtype  <= '0;
            r_size    <= '0;
            r_address <= '0;
            r_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dm || w_grant_if) begin
                        r_owner   <= w_grant_dm;
                        r_l15_val <= 1'b1;
                        r_state   <= ST_REQ;
                        r_rqtype  <= w_grant_dm ? i_dm_rqtype  : i_if_rqtype;
                        r_size    <= w_grant_dm ? i_dm_size    : i_if_size;
                        r_address <= w_grant_dm ? i_dm_address : i_if_address;
                        r_data    <= w_grant_dm ? i_dm_data    : i_if_data;
                        // Only DM wins that leave IF waiting count toward starvation.
                        if (w_grant_dm && i_if_req_val) begin
                            if (r_cnt != CNT_W'(STARVE_LIMIT)) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_l15_transducer_header_ack) begin
                        r_l15_val <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_l15_val <= 1'b0;
                end
            endcase
        end
    end

`ifdef L15_ARB_PERF_EN
    logic [31:0] r_perf_if_grants;
    logic [31:0] r_perf_dm_grants;
    logic [31:0] r_perf_if_wait_cycles;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_if_grants      <= '0;
            r_perf_dm_grants      <= '0;
            r_perf_if_wait_cycles <= '0;
        end else begin
            r_perf_if_grants      <= r_perf_if_grants + 32'(w_grant_if);
            r_perf_dm_grants      <= r_perf_dm_grants + 32'(w_grant_dm);
            r_perf_if_wait_cycles <= r_perf_if_wait_cycles + 32'(i_if_req_val && !w_grant_if);
        end
    end

    assign o_perf_if_grants      = r_perf_if_grants;
    assign o_perf_dm_grants      = r_perf_dm_grants;
    assign o_perf_if_wait_cycles = r_perf_if_wait_cycles;
`endif

    // Requesters must hold val until captured; L1.5 responses are only legal once the header is taken.
    a_if_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_if_req_val && !o_if_header_ack) |=> i_if_req_val);
    a_dm_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_dm_req_val && !o_dm_header_ack) |=> i_dm_req_val);
    a_l15_resp: assert property (@(posedge i_clk) disable iff (i_rst)
        i_l15_transducer_val |-> ((r_state == ST_RESP) ||
                                  ((r_state == ST_REQ) && i_l15_transducer_header_ack)));

endmodule

// File: tb/tb_l15_port_arbiter.sv
// tb/tb_l15_port_arbiter.sv - randomized scoreboard bench for l15_port_arbiter
`timescale 1ns/1ps
module tb_l15_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        owner;
        logic [4:0]  rq;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [3:0]  rt;
    } rsp_t;

    logic        clk, rst;
    logic        if_req_val, dm_req_val, if_resp_ack, dm_resp_ack;
    logic [4:0]  if_rqtype, dm_rqtype;
    logic [2:0]  if_size, dm_size;
    logic [31:0] if_address, if_data, dm_address, dm_data;
    logic        l15_hack, l15_val;
    logic [63:0] l15_d0, l15_d1;
    logic [3:0]  l15_rt;

    logic        o_if_hack, o_if_rv, o_dm_hack, o_dm_rv;
    logic [63:0] o_if_d0, o_if_d1, o_dm_d0, o_dm_d1;
    logic [3:0]  o_if_rt, o_dm_rt;
    logic        o_tval, o_rack, o_owner, o_busy, o_dm_pend;
    logic [4:0]  o_rq;
    logic [2:0]  o_sz;
    logic [31:0] o_addr, o_data;
`ifdef L15_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_dm_grants, perf_if_wait;
`endif

    l15_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req_val(if_req_val), .i_if_rqtype(if_rqtype), .i_if_size(if_size),
        .i_if_address(if_address), .i_if_data(if_data),
        .o_if_header_ack(o_if_hack), .o_if_resp_val(o_if_rv),
        .o_if_resp_data_0(o_if_d0), .o_if_resp_data_1(o_if_d1),
        .o_if_resp_returntype(o_if_rt), .i_if_resp_ack(if_resp_ack),
        .i_dm_req_val(dm_req_val), .i_dm_rqtype(dm_rqtype), .i_dm_size(dm_size),
        .i_dm_address(dm_address), .i_dm_data(dm_data),
        .o_dm_header_ack(o_dm_hack), .o_dm_resp_val(o_dm_rv),
        .o_dm_resp_data_0(o_dm_d0), .o_dm_resp_data_1(o_dm_d1),
        .o_dm_resp_returntype(o_dm_rt), .i_dm_resp_ack(dm_resp_ack),
        .o_transducer_l15_val(o_tval), .o_transducer_l15_rqtype(o_rq),
        .o_transducer_l15_size(o_sz), .o_transducer_l15_address(o_addr),
        .o_transducer_l15_data(o_data),
        .i_l15_transducer_header_ack(l15_hack), .i_l15_transducer_val(l15_val),
        .i_l15_transducer_data_0(l15_d0), .i_l15_transducer_data_1(l15_d1),
        .i_l15_transducer_returntype(l15_rt),
        .o_transducer_l15_req_ack(o_rack), .o_owner(o_owner), .o_busy(o_busy),
        .o_dm_pending(o_dm_pend)
`ifdef L15_ARB_PERF_EN
        ,
        .o_perf_if_grants(perf_if_grants), .o_perf_dm_grants(perf_dm_grants),
        .o_perf_if_wait_cycles(perf_if_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 free, 1 request presented, 2 awaiting response.
    req_t req_q[$];
    rsp_t rsp_q[$];
    int   m_phase, m_cnt, ack_dly;
    logic m_owner;
    logic drop_if, drop_dm, drop_l15;
    logic e_busy, e_tval, e_if_ack, e_dm_ack, e_dm_pend, e_if_rv, e_dm_rv, e_rack;
    int   if_budget, dm_budget, p_if, p_dm;
    logic fixed;

    task automatic model_reset();
        req_q.delete();
        rsp_q.delete();
        m_phase = 0; m_cnt = 0; ack_dly = 0; m_owner = 1'b0;
        drop_if = 1'b0; drop_dm = 1'b0; drop_l15 = 1'b0;
        e_busy = 1'b0; e_tval = 1'b0; e_if_ack = 1'b0; e_dm_ack = 1'b0;
        e_dm_pend = 1'b0; e_if_rv = 1'b0; e_dm_rv = 1'b0; e_rack = 1'b0;
        if_req_val = 1'b0; dm_req_val = 1'b0; if_resp_ack = 1'b0; dm_resp_ack = 1'b0;
        l15_hack = 1'b0; l15_val = 1'b0;
    endtask

    task automatic cycle();
        logic win_dm, own_ack;
        @(negedge clk);
        if (drop_if)  if_req_val = 1'b0;
        if (drop_dm)  dm_req_val = 1'b0;
        if (drop_l15) l15_val = 1'b0;
        drop_if = 1'b0; drop_dm = 1'b0; drop_l15 = 1'b0;
        if (!if_req_val && if_budget > 0 && $urandom_range(0, 99) < p_if) begin
            if_budget--;
            if_req_val = 1'b1;
            if (fixed) begin
                if_rqtype = 5'd0; if_size = 3'd3; if_address = 32'h0000_1000; if_data = 32'h0;
            end else begin
                if_rqtype = 5'($urandom); if_size = 3'($urandom);
                if_address = $urandom; if_data = $urandom;
            end
        end
        if (!dm_req_val && dm_budget > 0 && $urandom_range(0, 99) < p_dm) begin
            dm_budget--;
            dm_req_val = 1'b1;
            if (fixed) begin
                dm_rqtype = 5'd1; dm_size = 3'd2; dm_address = 32'h0000_2004; dm_data = 32'h55AA_55AA;
            end else begin
                dm_rqtype = 5'($urandom); dm_size = 3'($urandom);
                dm_address = $urandom; dm_data = $urandom;
            end
        end
        if_resp_ack = ($urandom_range(0, 2) != 0);
        dm_resp_ack = ($urandom_range(0, 2) != 0);
        l15_hack = 1'b0;
        if (m_phase == 1) begin
            if (ack_dly == 0) l15_hack = 1'b1;
            else ack_dly--;
        end
        if (!l15_val && ((m_phase == 1 && l15_hack) || m_phase == 2) && $urandom_range(0, 1) == 1) begin
            l15_val = 1'b1;
            l15_d0 = fixed ? 64'hDEADBEEF_00000013 : {$urandom, $urandom};
            l15_d1 = {$urandom, $urandom};
            l15_rt = 4'($urandom);
        end

        own_ack   = m_owner ? dm_resp_ack : if_resp_ack;
        e_busy    = (m_phase != 0);
        e_tval    = (m_phase == 1);
        e_if_rv   = (m_phase == 2) && l15_val && !m_owner;
        e_dm_rv   = (m_phase == 2) && l15_val && m_owner;
        e_rack    = (m_phase == 2) && l15_val && own_ack;
        e_if_ack  = 1'b0;
        e_dm_ack  = 1'b0;
        case (m_phase)
            0: if (if_req_val || dm_req_val) begin
                win_dm   = dm_req_val && !(if_req_val && m_cnt >= STARVE_LIMIT);
                m_owner  = win_dm;
                e_dm_ack = win_dm;
                e_if_ack = !win_dm;
                if (win_dm) begin
                    drop_dm = 1'b1;
                    req_q.push_back(req_t'({1'b1, dm_rqtype, dm_size, dm_address, dm_data}));
                    if (if_req_val) m_cnt = (m_cnt < STARVE_LIMIT) ? m_cnt + 1 : m_cnt;
                    else m_cnt = 0;
                end else begin
                    drop_if = 1'b1;
                    req_q.push_back(req_t'({1'b0, if_rqtype, if_size, if_address, if_data}));
                    m_cnt = 0;
                end
                m_phase = 1;
                ack_dly = fixed ? 3 : $urandom_range(0, 3);
            end
            1: if (l15_hack) m_phase = 2;
            default: if (e_rack) begin
                rsp_q.push_back(rsp_t'({m_owner, l15_d0, l15_d1, l15_rt}));
                drop_l15 = 1'b1;
                m_phase = 0;
            end
        endcase
        e_dm_pend = dm_req_val && !e_dm_ack;
    endtask

    task automatic run_until_idle(input string name, input int bound);
        int n = 0;
        while ((m_phase != 0 || if_req_val || dm_req_val || if_budget > 0 || dm_budget > 0) && n < bound) begin
            cycle();
            n++;
        end
        chk({"timeout_", name}, 128'(n >= bound), 128'(0));
    endtask

    // Monitor: compares DUT outputs against the model each cycle, popping queued transactions.
    initial begin
        req_t r;
        rsp_t s;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk("reset_outputs", 128'(|{o_if_hack, o_if_rv, o_if_d0, o_if_d1, o_if_rt,
                                           o_dm_hack, o_dm_rv, o_dm_d0, o_dm_d1, o_dm_rt,
                                           o_tval, o_rq, o_sz, o_addr, o_data,
                                           o_rack, o_owner, o_busy, o_dm_pend}), 128'(0));
            end else begin
                chk("busy", 128'(o_busy), 128'(e_busy));
                chk("l15_val", 128'(o_tval), 128'(e_tval));
                chk("header_acks", 128'({o_if_hack, o_dm_hack}), 128'({e_if_ack, e_dm_ack}));
                chk("dm_pending", 128'(o_dm_pend), 128'(e_dm_pend));
                chk("resp_vals", 128'({o_if_rv, o_dm_rv, o_rack}), 128'({e_if_rv, e_dm_rv, e_rack}));
                if (o_tval) begin
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 128'(1), 128'(0));
                    end else begin
                        r = req_q[0];
                        chk("req_payload", 128'({o_owner, o_rq, o_sz, o_addr, o_data}), 128'(r));
                        if (l15_hack) void'(req_q.pop_front());
                    end
                end
                if (o_rack) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 128'(1), 128'(0));
                    end else begin
                        s = rsp_q.pop_front();
                        chk("rsp_owner", 128'({o_if_rv, o_dm_rv}), 128'(s.owner ? 2'b01 : 2'b10));
                        chk("rsp_data", s.owner ? {o_dm_d0, o_dm_d1} : {o_if_d0, o_if_d1}, {s.d0, s.d1});
                        chk("rsp_type", 128'(s.owner ? o_dm_rt : o_if_rt), 128'(s.rt));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        if_rqtype = '0; if_size = '0; if_address = '0; if_data = '0;
        dm_rqtype = '0; dm_size = '0; dm_address = '0; dm_data = '0;
        l15_d0 = '0; l15_d1 = '0; l15_rt = '0;
        if_budget = 0; dm_budget = 0; p_if = 0; p_dm = 0; fixed = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Lone IF load, then simultaneous IF/DM with the counter at zero.
        if_budget = 1; p_if = 100;
        run_until_idle("single_if", 200);
        if_budget = 1; dm_budget = 1; p_dm = 100;
        run_until_idle("both_req", 300);

        // DM streams while IF waits: IF must win on the fifth arbitration.
        fixed = 1'b0;
        if_budget = 1; dm_budget = 6;
        run_until_idle("starve", 600);

        if_budget = 1000; dm_budget = 1000; p_if = 30; p_dm = 30;
        repeat (1500) cycle();
        if_budget = 0; dm_budget = 0;
        run_until_idle("random", 300);

        // Reset while a response is outstanding.
        if_budget = 1; p_if = 100;
        n = 0;
        while (m_phase != 2 && n < 100) begin
            cycle();
            n++;
        end
        chk("timeout_reach_resp", 128'(n >= 100), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        if_budget = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        if_budget = 1;
        run_until_idle("after_reset", 200);

        repeat (2) cycle();
        chk("req_q_empty", 128'(req_q.size()), 128'(0));
        chk("rsp_q_empty", 128'(rsp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/l15_port_arbiter.md
Name: l15_port_arbiter

Overview:
- Shares the single OpenPiton L1.5 transducer port between two requesters: instruction fetch (IF) and data memory (DM, execute stage).
- Allows one outstanding transaction at a time. Registers the winning request, drives it to the L1.5, and returns the response to the owner only.
- Grants DM first, with a starvation limit that protects IF.
- Exports DM-pending status so issue/decode can stall.

Parameters:
- STARVE_LIMIT, 4: consecutive DM grants allowed while IF is waiting; then IF is granted once.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req_val  in  1  IF request valid; held with payload until if_header_ack
- if_rqtype/if_size/if_address/if_data  in  5/3/32/32  IF request payload
- if_header_ack  out  1  one-cycle pulse: IF request captured
- if_resp_val  out  1  IF response valid
- if_resp_data_0/if_resp_data_1  out  64/64  IF response data
- if_resp_returntype  out  4  IF response type
- if_resp_ack  in  1  IF consumes response
- dm_req_val, dm_rqtype, dm_size, dm_address, dm_data, dm_header_ack, dm_resp_val, dm_resp_data_0, dm_resp_data_1, dm_resp_returntype, dm_resp_ack: same as the IF set, for DM
- transducer_l15_val  out  1  request valid to L1.5
- transducer_l15_rqtype/size/address/data  out  5/3/32/32  registered request payload
- l15_transducer_header_ack  in  1  L1.5 accepted request
- l15_transducer_val  in  1  L1.5 response valid
- l15_transducer_data_0/data_1  in  64/64  response data
- l15_transducer_returntype  in  4  response type
- transducer_l15_req_ack  out  1  response consumed
- owner  out  1  0 = IF, 1 = DM; valid when busy
- busy  out  1  transaction in flight
- dm_pending  out  1  dm_req_val high and DM not yet captured

Behaviour:
- Reset: asynchronous, active-high. State IDLE, all outputs 0, payload registers 0, starvation counter 0, owner 0.
- States: IDLE, REQ, RESP.
- IDLE:
  - If any request is valid, pick a winner. DM wins unless if_req_val=1 and cnt==STARVE_LIMIT.
  - Same cycle: pulse the winner's header_ack, latch its payload, set owner, go to REQ.
  - Loser sees no header_ack and keeps its request held.
- REQ:
  - transducer_l15_val=1 with the latched payload. The payload is stable for the whole state.
  - On l15_transducer_header_ack: drop val the next cycle and go to RESP.
- RESP:
  - Forward l15_transducer_val, data and returntype combinationally to the owner's resp_* only. The other side's resp_val stays 0.
  - transducer_l15_req_ack = owner's resp_ack, gated by l15_transducer_val.
  - When l15_transducer_val & owner resp_ack: go to IDLE.
  - A response arriving in the same cycle as the header_ack, while still in REQ, is accepted: go directly to RESP handling and forward it the following cycle. The L1.5 holds val until req_ack.
- Starvation counter:
  - +1 on a DM grant while if_req_val=1.
  - Cleared on any IF grant, or on a DM grant with if_req_val=0.
  - Saturates at STARVE_LIMIT.
- Latency: request visible to the L1.5 one cycle after the grant. Back-to-back transactions cost one IDLE cycle.
- busy = (state != IDLE).
- dm_pending is combinational: dm_req_val & ~dm_header_ack.
- Simultaneous IF and DM requests with cnt<STARVE_LIMIT: DM wins.
- A requester dropping val before its header_ack is a protocol violation; assert in simulation.
- l15_transducer_val in IDLE or REQ before header_ack: ignored, transducer_l15_req_ack=0. Assert in simulation.
- Reset mid-transaction: immediate return to IDLE; in-flight response discarded.

Optional Feature:
- Macro: L15_ARB_PERF_EN.
- Defined: adds outputs perf_if_grants[31:0], perf_dm_grants[31:0] and perf_if_wait_cycles[31:0].
  - perf_if_wait_cycles counts cycles with if_req_val=1 and no IF grant.
  - All three wrap at 2^32 and reset to 0.
- Undefined: no counters and no ports. Core behaviour is identical.

Test Plan:
- Single IF load, address 0x0000_1000 → if_header_ack at cycle 0, transducer_l15_val cycle 1; response data_0=0xDEADBEEF_00000013 → if_resp_val=1, dm_resp_val=0, back to IDLE after if_resp_ack.
- IF and DM both request in IDLE with cnt=0 → DM granted (owner=1), dm_pending=0 after grant; IF granted on the next IDLE.
- DM requests continuously and IF is held, STARVE_LIMIT=4 → 4 DM grants, then IF granted on the 5th; counter returns to 0.
- L1.5 delays header_ack 3 cycles → transducer_l15_val and payload (address 0x2004, data 0x55AA55AA) stable all 3 cycles; val low the cycle after the ack.
- Owner holds resp_ack=0 for 2 cycles → transducer_l15_req_ack=0 meanwhile; state stays RESP; exits the cycle ack=1.
- rst asserted while in RESP → all outputs 0 immediately; next IF request is served normally.
